// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package muldiv_pkg;

  // Operation encodings as presented on the op port.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

  // Ceiling log2, used to size the step counter so it can hold WIDTH.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/muldiv_unit_sign_mag_conv.sv
// Sign/magnitude converter: splits a two's-complement value into sign + magnitude, or negates on request.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module sign_mag_conv #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic             tc,
  input  logic             neg,
  output logic [WIDTH-1:0] mag,
  output logic             sgn
);

  // The sign only exists when the value is interpreted as two's complement.
  assign sgn = tc & din[WIDTH-1];

  // Negate either to strip a negative sign (operands) or to apply a result sign.
  assign mag = (sgn | neg) ? (~din + {{(WIDTH-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO with MTHI/MTLO writes; one shift-add/shift-subtract step per cycle.
// Latency: start sampled at edge N gives a one-cycle done after edge N+WIDTH+1; busy for WIDTH+1 cycles.
// Backpressure: start and MTHI/MTLO are ignored while busy; no queueing, the control unit stalls on busy.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = clog2(WIDTH + 1);

  state_e             state;
  state_e             state_nxt;
  op_e                op_q;
  logic               a_sgn_q;
  logic               b_sgn_q;
  // Multiplicand for multiplies, divisor for divides.
  logic [WIDTH-1:0]   opnd_q;
  // {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] sr_q;
  logic [CW-1:0]      cnt_q;

  logic               signed_op;
  logic               a_sgn;
  logic               b_sgn;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic               is_div_q;
  logic               prod_neg;
  logic               quo_neg;
  logic               rem_neg;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;
  logic [2:0]         res_sgn_unused;

  logic [WIDTH:0]     add_x;
  logic [WIDTH:0]     add_y;
  logic [WIDTH:0]     add_s;
  logic [2*WIDTH-1:0] sr_step;

  assign busy      = (state != IDLE);
  assign signed_op = ~op[0];
  assign is_div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU);

  // Result signs: product and quotient follow sign(a)^sign(b), remainder follows the dividend.
  assign prod_neg = (op_q == OP_MULT) & (a_sgn_q ^ b_sgn_q);
  assign quo_neg  = (op_q == OP_DIV) & (a_sgn_q ^ b_sgn_q);
  assign rem_neg  = (op_q == OP_DIV) & a_sgn_q;

  sign_mag_conv #(.WIDTH(WIDTH)) u_conv_a (
    .din (a),
    .tc  (signed_op),
    .neg (1'b0),
    .mag (a_mag),
    .sgn (a_sgn)
  );

  sign_mag_conv #(.WIDTH(WIDTH)) u_conv_b (
    .din (b),
    .tc  (signed_op),
    .neg (1'b0),
    .mag (b_mag),
    .sgn (b_sgn)
  );

  sign_mag_conv #(.WIDTH(2*WIDTH)) u_conv_prod (
    .din (sr_q),
    .tc  (1'b0),
    .neg (prod_neg),
    .mag (prod_res),
    .sgn (res_sgn_unused[0])
  );

  sign_mag_conv #(.WIDTH(WIDTH)) u_conv_quo (
    .din (sr_q[WIDTH-1:0]),
    .tc  (1'b0),
    .neg (quo_neg),
    .mag (quo_res),
    .sgn (res_sgn_unused[1])
  );

  sign_mag_conv #(.WIDTH(WIDTH)) u_conv_rem (
    .din (sr_q[2*WIDTH-1:WIDTH]),
    .tc  (1'b0),
    .neg (rem_neg),
    .mag (rem_res),
    .sgn (res_sgn_unused[2])
  );

  // One iteration: shared WIDTH+1-bit adder adds the multiplicand or subtracts the divisor.
  always_comb begin
    add_x   = '0;
    add_y   = {1'b0, opnd_q};
    add_s   = '0;
    sr_step = sr_q;
    if (is_div_q) begin
      // Trial subtract from {remainder, next dividend bit}; MSB of the difference is the borrow.
      add_x = sr_q[2*WIDTH-1:WIDTH-1];
      add_s = add_x - add_y;
      if (!add_s[WIDTH]) begin
        sr_step = {add_s[WIDTH-1:0], sr_q[WIDTH-2:0], 1'b1};
      end else begin
        sr_step = {sr_q[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      // Add multiplicand when the current multiplier bit is set, then shift right with carry.
      add_x = {1'b0, sr_q[2*WIDTH-1:WIDTH]};
      add_s = add_x + add_y;
      if (sr_q[0]) begin
        sr_step = {add_s, sr_q[WIDTH-1:1]};
      end else begin
        sr_step = {1'b0, sr_q[2*WIDTH-1:1]};
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: launch on start, run WIDTH steps, one fix-up cycle, back to idle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt_q == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and architectural HI/LO: latch operands, iterate, then commit results.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= OP_MULT;
      a_sgn_q     <= 1'b0;
      b_sgn_q     <= 1'b0;
      opnd_q      <= '0;
      sr_q        <= '0;
      cnt_q       <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          // MT writes land even alongside an accepted start; the op result overwrites later.
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (start) begin
            op_q    <= op_e'(op);
            a_sgn_q <= a_sgn;
            b_sgn_q <= b_sgn;
            cnt_q   <= CW'(WIDTH);
            if (op[1]) begin
              opnd_q <= b_mag;
              sr_q   <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              opnd_q <= a_mag;
              sr_q   <= {{WIDTH{1'b0}}, b_mag};
            end
          end
        end
        RUN: begin
          sr_q  <= sr_step;
          cnt_q <= cnt_q - CW'(1);
        end
        FIX: begin
          done <= 1'b1;
          if (is_div_q) begin
            // Divide by zero still takes full latency but leaves HI/LO untouched.
            if (opnd_q == '0) begin
              div_by_zero <= 1'b1;
            end else begin
              hi <= rem_res;
              lo <= quo_res;
            end
          end else begin
            hi <= prod_res[2*WIDTH-1:WIDTH];
            lo <= prod_res[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + random bench for muldiv_unit with a result scoreboard.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_pushed = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {div_by_zero, hi, lo} given the previous HI/LO.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] ph, input logic [31:0] pl);
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin p = sx * sy; return {1'b0, p}; end
      2'b01: begin p = {32'd0, x} * {32'd0, y}; return {1'b0, p}; end
      2'b10: begin
        if (y == 32'd0) return {1'b1, ph, pl};
        q = sx / sy;
        r = sx % sy;
        return {1'b0, 32'(r), 32'(q)};
      end
      default: begin
        if (y == 32'd0) return {1'b1, ph, pl};
        return {1'b0, x % y, x / y};
      end
    endcase
  endfunction

  // Scoreboard: every done pops one expectation; div_by_zero must only appear with done.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected_done: queue size %0d expected nonzero", sb.size());
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk($sformatf("sb%0d_hi", e.id), {32'd0, hi}, {32'd0, e.hi});
        chk($sformatf("sb%0d_lo", e.id), {32'd0, lo}, {32'd0, e.lo});
        chk($sformatf("sb%0d_dbz", e.id), {63'd0, div_by_zero}, {63'd0, e.dbz});
      end
    end else if (div_by_zero === 1'b1) begin
      chk("dbz_without_done", {63'd0, done}, 64'd1);
    end
  end

  // Drive a start at the current time (just after a negedge); optionally record the expectation.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit expect_result);
    logic [64:0] r;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (expect_result) begin
      r = model(o, x, y, model_hi, model_lo);
      sb.push_back('{n_pushed, r[64], r[63:32], r[31:0]});
      n_pushed++;
      model_hi = r[63:32];
      model_lo = r[31:0];
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait (bounded) for done; ends at the negedge of the done cycle.
  task automatic wait_done(input string tag, output int edges, output int busy_cycles);
    edges       = 1;
    busy_cycles = 0;
    while (edges < 200) begin
      @(negedge clk);
      if (done === 1'b1) break;
      if (busy === 1'b1) busy_cycles++;
      edges++;
    end
    n_assert++;
    assert (done === 1'b1) else begin
      n_fail++;
      $error("FAIL %s_timeout: done=%b after %0d edges, expected 1", tag, done, edges);
    end
    chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int e;
    int bc;
    @(negedge clk);
    launch(o, x, y, 1'b1);
    wait_done(tag, e, bc);
  endtask

  task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
    @(negedge clk);
    mthi  = h;
    mtlo  = l;
    wdata = d;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    mtlo = 1'b0;
    if (h) model_hi = d;
    if (l) model_lo = d;
  endtask

  initial begin
    int          e;
    int          bc;
    int          done_seen;
    logic [31:0] hold_hi;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dbz",  {63'd0, div_by_zero}, 64'd0);
    chk("rst_hi",   {32'd0, hi}, 64'd0);
    chk("rst_lo",   {32'd0, lo}, 64'd0);
    rst = 1'b0;

    // MULTU max*max with latency and busy-length checks.
    @(negedge clk);
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("multu_max", e, bc);
    chk("multu_max_edges", 64'(e), 64'd34);
    chk("multu_max_busy_cycles", 64'(bc), 64'd33);
    chk("multu_max_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    chk("multu_max_done_one_cycle", {63'd0, done}, 64'd0);

    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
    chk("mult_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000);
    chk("mult_minmin_hilo", {hi, lo}, 64'h4000_0000_0000_0000);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    chk("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_7_2", 2'b11, 32'd7, 32'd2);
    chk("divu_7_2_hilo", {hi, lo}, 64'h0000_0001_0000_0003);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    // MTHI, MTLO, then divide by zero keeps them.
    mt_write(1'b1, 1'b0, 32'h0000_1234);
    @(negedge clk);
    chk("mthi", {32'd0, hi}, 64'h1234);
    mt_write(1'b0, 1'b1, 32'h0000_5678);
    @(negedge clk);
    chk("mtlo", {32'd0, lo}, 64'h5678);
    run_op("divu_by0", 2'b11, 32'd9, 32'd0);
    chk("divu_by0_dbz", {63'd0, div_by_zero}, 64'd1);
    chk("divu_by0_hilo", {hi, lo}, 64'h0000_1234_0000_5678);

    // Ignored start/mthi mid-run, then back-to-back start in the done cycle.
    hold_hi = model_hi;
    @(negedge clk);
    launch(2'b01, 32'd3, 32'd5, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op    = 2'b10;
    a     = 32'd100;
    b     = 32'd3;
    mthi  = 1'b1;
    wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    mthi  = 1'b0;
    @(negedge clk);
    chk("busy_mthi_ignored", {32'd0, hi}, {32'd0, hold_hi});
    wait_done("multu_3_5", e, bc);
    chk("multu_3_5_hilo", {hi, lo}, 64'h0000_0000_0000_000F);
    launch(2'b11, 32'd7, 32'd2, 1'b1);
    wait_done("b2b_divu", e, bc);
    chk("b2b_divu_edges", 64'(e), 64'd34);
    chk("b2b_divu_hilo", {hi, lo}, 64'h0000_0001_0000_0003);

    // MTHI+MTLO together, then MTHI alongside an accepted start.
    mt_write(1'b1, 1'b1, 32'h0000_ABCD);
    @(negedge clk);
    chk("mt_both", {hi, lo}, 64'h0000_ABCD_0000_ABCD);
    @(negedge clk);
    mthi     = 1'b1;
    wdata    = 32'h0000_1111;
    model_hi = 32'h0000_1111;
    launch(2'b01, 32'd2, 32'd3, 1'b1);
    mthi = 1'b0;
    @(negedge clk);
    chk("mt_with_start", {32'd0, hi}, 64'h1111);
    wait_done("mt_start_op", e, bc);
    chk("mt_start_op_hilo", {hi, lo}, 64'h0000_0000_0000_0006);

    // Reset mid-DIVU aborts it; no done follows, then a fresh op works.
    @(negedge clk);
    launch(2'b11, 32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);
    run_op("after_abort", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("after_abort_hilo", {hi, lo}, 64'h0000_0000_0000_0001);

    // Random operations checked against the reference model.
    for (int i = 0; i < 10; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      run_op($sformatf("rand%0d", i), ro, ra, rb);
    end

    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath: MULT, MULTU, DIV and DIVU into HI/LO registers, plus MTHI/MTLO writes.
- Generalises the 32-bit combinational adder to a parametrised-width, multi-cycle arithmetic block with a start/busy/done handshake.
- Runs one shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
- Sits beside the main ALU. The control unit stalls on busy.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each; iteration count = WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request to launch the operation in op
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  WIDTH  multiplicand / dividend (rs)
- b  input  WIDTH  multiplier / divisor (rt)
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; HI/LO valid
- div_by_zero  output  1  one-cycle pulse with done for DIV/DIVU with b==0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset: one clock and a synchronous, active-high reset. With rst high at a clk edge, on that edge:
  - state goes to IDLE
  - busy, done, div_by_zero, hi, lo all go to 0
  - any in-flight operation is aborted and no done is issued.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - start=1 latches op, a, b.
  - For signed ops, the magnitudes |a| and |b| and the result signs are also latched.
  - The step counter loads WIDTH, state goes to RUN, and busy=1 from the next cycle.
- RUN: one step per edge. The counter decrements, and after WIDTH steps the state goes to FIX.
- FIX:
  - Negates results where required.
  - Writes HI/LO and pulses done=1 for exactly the following cycle.
  - busy=0 in that same cycle; state goes to IDLE.
- Latency: start at edge N gives done high during the cycle after edge N+WIDTH+1 (WIDTH+2 edges).
- start while busy is ignored: no queueing, no effect on the running op.
- start in the cycle done is high is accepted, because the state is already IDLE.
- Multiply results:
  - {hi,lo} = full 2*WIDTH-bit product.
  - MULT is two's-complement signed; MULTU is unsigned.
- Divide results:
  - lo = quotient, hi = remainder.
  - DIV truncates toward zero, and the remainder takes the sign of the dividend.
  - DIVU is unsigned.
- Most-negative / -1 (DIV): lo = 100...0 and hi = 0 (wrapped result, no trap).
- Divide by zero:
  - Runs full latency.
  - div_by_zero=1 with done.
  - hi/lo keep their prior values.
- MTHI/MTLO:
  - Applied on the edge only when busy=0; ignored while busy.
  - mthi and mtlo together write both registers.
  - MTHI/MTLO in the same cycle as an accepted start: the write happens, and the op result later overwrites it.
- hi/lo are held stable during RUN; only FIX or MT writes change them.
- Internal datapath: a 2*WIDTH-bit shift register plus a WIDTH+1-bit adder/subtractor. No combinational path from inputs to outputs.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum: IDLE, RUN, FIX
  - counter width function clog2(WIDTH+1).
- Sub-module sign_mag_conv (parametrised WIDTH):
  - Converts a signed/unsigned operand to magnitude plus sign bit.
  - Performs conditional two's-complement negation.
  - Used for the operands in IDLE and for the results in FIX.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 edges after start; busy high for 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x1234 then MTLO 0x5678, then DIVU a=9 b=0 -> done and div_by_zero pulse together; hi=0x1234, lo=0x5678 unchanged.
- Start MULTU 3*5; pulse start with DIV and pulse mthi at iteration 5 -> both ignored; result hi=0, lo=15. A back-to-back start in the done cycle is accepted.
- rst=1 at iteration 10 of a DIVU -> next cycle busy=0, hi=lo=0, and no done ever pulses. A new op afterwards completes normally.
